or1200_operand_fwd_mux: RTL and testbench
=========================================

# or1200_operand_fwd_mux

Parametrised register-file operand selector and EX-stage operand register for the OR1200 pipeline. It supports NUM_OPS read operands and NUM_FWD forwarding sources, each source with its own valid qualifier. It keeps the per-operand freeze-save behaviour so that an operand captured during an ID freeze is not overwritten. It adds a forwarding-not-ready stall and an EX operand-valid flag, so the decoder can park on a pending multi-cycle result (load, MAC) instead of consuming stale data.

## Interface
Parameters:
- WIDTH, 32, operand width in bits.
- NUM_OPS, 2, number of operands (2..4).
- NUM_FWD, 2, number of forwarding sources (1..6).
- SEL_W, localparam = $clog2(NUM_FWD+2), select code width per operand.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- id_freeze  in  1  ID stage frozen.
- ex_freeze  in  1  EX stage frozen.
- rf_data  in  NUM_OPS*WIDTH  register-file read data; operand i is slice [i*WIDTH +: WIDTH].
- simm  in  WIDTH  sign-extended immediate.
- fwd_data  in  NUM_FWD*WIDTH  forwarding values; source k is slice [k*WIDTH +: WIDTH].
- fwd_valid  in  NUM_FWD  source k holds a final result.
- sel  in  NUM_OPS*SEL_W  per-operand select code.
- muxed  out  NUM_OPS*WIDTH  combinational selected value per operand.
- operand  out  NUM_OPS*WIDTH  registered EX operands.
- saved  out  NUM_OPS  per-operand HELD flag.
- fwd_stall  out  1  combinational request to freeze ID/IF.
- op_valid  out  1  registered flag: EX operands are genuine (not a bubble).

## Operation
- Select decode for operand i:
  - Code 0: rf_data slice i.
  - Code 1: simm.
  - Code 2+k with k<NUM_FWD: fwd_data slice k.
  - Any other code: rf_data slice i.
- ready_i is 1 unless sel_i selects source k and fwd_valid[k]=0. fwd_valid bits of unselected sources are ignored.
- fwd_stall = OR over i of (!ready_i && !saved_i).
- Each operand has a two-state FSM, LIVE (saved=0) or HELD (saved=1). Rules, in priority order:
  - rst=0: operand<=0, saved<=0, op_valid<=0. Reset overrides the freezes.
  - ex_freeze=1: operand, saved and op_valid all hold.
  - LIVE, ready, id_freeze=1: operand<=muxed, go to HELD.
  - LIVE, ready, id_freeze=0: operand<=muxed, stay LIVE.
  - LIVE, !ready: operand holds, stay LIVE (capture deferred).
  - HELD, id_freeze=0: go to LIVE, operand holds this cycle.
  - HELD, id_freeze=1: hold.
- op_valid: when ex_freeze=0, op_valid<=!fwd_stall; otherwise it holds.
- Operands are independent. One operand may capture while another is deferred, but op_valid stays 0 until no operand is deferred.
- No arithmetic is performed; values pass bit-exact.

## Timing
- muxed and fwd_stall: zero latency, combinational from sel, rf_data, simm, fwd_data, fwd_valid and saved.
- operand and op_valid: one cycle after the qualifying edge.
- A source turning valid in cycle t:
  - fwd_stall drops in cycle t.
  - operand and op_valid=1 appear after edge t+1.
- Reset value of every output:
  - operand = 0, saved = 0, op_valid = 0.
  - muxed follows its inputs; fwd_stall is 0 when sel selects RF.
- Reset asserted mid-freeze or mid-stall: state cleared on that edge, regardless of freezes.
- Simultaneous id_freeze=1 and !ready: no capture and no HELD entry. The operand re-evaluates each cycle until ready.

## Test plan
- Reset: rst=0 for 2 cycles with ex_freeze=1 and random inputs -> operand=0, saved=0, op_valid=0 after the first edge.
- Mux sweep, NUM_FWD=2, NUM_OPS=2, rf_data={0xB,0xA}, simm=0x5, fwd={0x22,0x11}, all valid, applied to each operand -> muxed_i = 0xA/0xB for code 0, 0x5 for 1, 0x11 for 2, 0x22 for 3, and rf_data slice i for out-of-range code 7 (when SEL_W>=3). operand_i equals muxed_i one cycle later.
- Forward not ready: sel0=2, fwd_valid[0]=0 for 3 cycles, then 1 with fwd_data[0]=0x1234 -> fwd_stall=1 for 3 cycles and operand0 unchanged; after the next edge operand0=0x1234 and op_valid=1.
- Freeze save: id_freeze=1, ex_freeze=0, muxed0=0x77, then muxed0 changes to 0x88 -> operand0=0x77 with saved0=1 and stays 0x77; after id_freeze falls, saved0 clears and operand0 still reads 0x77 that cycle.
- ex_freeze: ex_freeze=1 while sel/data toggle and a stall is raised -> operand, saved and op_valid are frozen.
- Mixed operands: op0 selects invalid fwd[1], op1 selects simm=0x9 -> operand1=0x9, operand0 held, op_valid=0.

Source files
------------

// File: rtl/or1200_operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// or1200_operand_fwd_mux
//   Register-file operand selector and EX-stage operand register. Each operand
//   lane picks RF data, the immediate or one of NUM_FWD forwarding sources.
//   A lane whose forwarding source is still pending (for example a load or
//   MAC result) defers its capture and raises fwd_stall. op_valid marks EX
//   operands that are genuine rather than a bubble.
//
//   Ports
//     clk        pipeline clock (rising edge)
//     rst        synchronous reset, active low
//     id_freeze  ID stage frozen: a ready lane captures once, then holds
//     ex_freeze  EX stage frozen: all registered state holds
//     rf_data    NUM_OPS x WIDTH register-file read data
//     simm       sign-extended immediate
//     fwd_data   NUM_FWD x WIDTH forwarding values
//     fwd_valid  per-source final-result qualifier
//     sel        NUM_OPS x SEL_W select codes
//     muxed      combinational selected value per operand
//     operand    registered EX operands
//     saved      per-operand HELD flag
//     fwd_stall  combinational freeze request to ID/IF
//     op_valid   registered "EX operands are genuine" flag
// ---------------------------------------------------------------------------

// Per-operand lane: select decode, readiness and the LIVE/HELD save FSM.
module or1200_operand_fwd_lane #(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     id_freeze_i,
  input  logic                     ex_freeze_i,
  input  logic [WIDTH-1:0]         rf_data_i,
  input  logic [WIDTH-1:0]         simm_i,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data_i,
  input  logic [NUM_FWD-1:0]       fwd_valid_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [WIDTH-1:0]         muxed_o,
  output logic [WIDTH-1:0]         operand_o,
  output logic                     saved_o,
  output logic                     stall_o
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] muxed;
  logic             ready;

  // Select decode. Unused codes fall back to RF data. Only the selected
  // source's valid bit matters for readiness.
  always_comb begin
    muxed = rf_data_i;
    ready = 1'b1;
    if (sel_i == SEL_W'(1)) muxed = simm_i;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sel_i == SEL_W'(k + 2)) begin
        muxed = fwd_data_i[k*WIDTH +: WIDTH];
        ready = fwd_valid_i[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= LIVE;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
    end
  end

  // Next state. A not-ready lane never enters HELD, even under id_freeze:
  // it keeps re-evaluating until the source resolves. Leaving HELD does not
  // capture, so the saved value is still visible on that cycle.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    if (!ex_freeze_i) begin
      case (state_q)
        LIVE: begin
          if (ready) begin
            operand_d = muxed;
            if (id_freeze_i) state_d = HELD;
          end
        end
        HELD: begin
          if (!id_freeze_i) state_d = LIVE;
        end
        default: state_d = LIVE;
      endcase
    end
  end

  // Outputs. A HELD lane already owns its value, so it cannot stall.
  always_comb begin
    muxed_o   = muxed;
    operand_o = operand_q;
    saved_o   = (state_q == HELD);
    stall_o   = !ready && (state_q != HELD);
  end

endmodule

module or1200_operand_fwd_mux #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_OPS = 2,
  parameter  int NUM_FWD = 2,
  localparam int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_freeze,
  input  logic                     ex_freeze,
  input  logic [NUM_OPS*WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0]         simm,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_OPS*SEL_W-1:0] sel,
  output logic [NUM_OPS*WIDTH-1:0] muxed,
  output logic [NUM_OPS*WIDTH-1:0] operand,
  output logic [NUM_OPS-1:0]       saved,
  output logic                     fwd_stall,
  output logic                     op_valid
);

  logic [NUM_OPS-1:0] lane_stall;
  logic               op_valid_q, op_valid_d;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
    or1200_operand_fwd_lane #(
      .WIDTH  (WIDTH),
      .NUM_FWD(NUM_FWD),
      .SEL_W  (SEL_W)
    ) u_lane (
      .clk_i      (clk),
      .rst_ni     (rst),
      .id_freeze_i(id_freeze),
      .ex_freeze_i(ex_freeze),
      .rf_data_i  (rf_data[i*WIDTH +: WIDTH]),
      .simm_i     (simm),
      .fwd_data_i (fwd_data),
      .fwd_valid_i(fwd_valid),
      .sel_i      (sel[i*SEL_W +: SEL_W]),
      .muxed_o    (muxed[i*WIDTH +: WIDTH]),
      .operand_o  (operand[i*WIDTH +: WIDTH]),
      .saved_o    (saved[i]),
      .stall_o    (lane_stall[i])
    );
  end

  assign fwd_stall = |lane_stall;

  // EX operands are a bubble whenever any lane deferred its capture.
  always_comb begin
    op_valid_d = op_valid_q;
    if (!ex_freeze) op_valid_d = !fwd_stall;
  end

  always_ff @(posedge clk) begin
    if (!rst) op_valid_q <= 1'b0;
    else      op_valid_q <= op_valid_d;
  end

  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_or1200_operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// tb_or1200_operand_fwd_mux
//   Self-checking bench: a select-code table, directed multi-cycle sequences
//   (stall, freeze-save, ex_freeze, mixed lanes, reset) and a randomized run,
//   all shadowed by a per-operand behavioural model.
// ---------------------------------------------------------------------------
module tb_or1200_operand_fwd_mux;

  localparam int WIDTH   = 32;
  localparam int NUM_OPS = 2;
  localparam int NUM_FWD = 3;
  localparam int SEL_W   = $clog2(NUM_FWD + 2);

  logic clk, rst, id_freeze, ex_freeze;
  logic [NUM_OPS-1:0][WIDTH-1:0] rf_data;
  logic [WIDTH-1:0]              simm;
  logic [NUM_FWD-1:0][WIDTH-1:0] fwd_data;
  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_OPS-1:0][SEL_W-1:0] sel;
  logic [NUM_OPS-1:0][WIDTH-1:0] muxed, operand;
  logic [NUM_OPS-1:0]            saved;
  logic                          fwd_stall, op_valid;

  or1200_operand_fwd_mux #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
    .rf_data(rf_data), .simm(simm), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .sel(sel), .muxed(muxed), .operand(operand), .saved(saved),
    .fwd_stall(fwd_stall), .op_valid(op_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit comb_ok = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_op [NUM_OPS];
  bit               m_saved [NUM_OPS];
  bit               m_opv;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_mux(int i);
    int code = int'(sel[i]);
    if (code == 1) return simm;
    if (code >= 2 && code - 2 < NUM_FWD) return fwd_data[code-2];
    return rf_data[i];
  endfunction

  function automatic bit ref_ready(int i);
    int code = int'(sel[i]);
    if (code >= 2 && code - 2 < NUM_FWD) return fwd_valid[code-2];
    return 1'b1;
  endfunction

  function automatic bit ref_stall();
    bit s = 0;
    for (int i = 0; i < NUM_OPS; i++) if (!ref_ready(i) && !m_saved[i]) s = 1;
    return s;
  endfunction

  task automatic settle();
    #4;
  endtask

  // Check combinational outputs, advance the model, clock, check registers.
  task automatic tick();
    bit st;
    st = ref_stall();
    if (comb_ok) begin
      for (int i = 0; i < NUM_OPS; i++) chk($sformatf("muxed%0d", i), muxed[i], ref_mux(i));
      chk("fwd_stall", 32'(fwd_stall), 32'(st));
    end
    if (!rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin m_op[i] = '0; m_saved[i] = 0; end
      m_opv = 0;
      comb_ok = 1;
    end else if (!ex_freeze) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (m_saved[i]) begin
          if (!id_freeze) m_saved[i] = 0;
        end else if (ref_ready(i)) begin
          m_op[i]    = ref_mux(i);
          m_saved[i] = id_freeze;
        end
      end
      m_opv = !st;
    end
    @(posedge clk); #1;
    if (comb_ok) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        chk($sformatf("operand%0d", i), operand[i], m_op[i]);
        chk($sformatf("saved%0d", i), 32'(saved[i]), 32'(m_saved[i]));
      end
      chk("op_valid", 32'(op_valid), 32'(m_opv));
    end
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NUM_OPS; i++) begin
      rf_data[i] = $urandom;
      sel[i]     = SEL_W'($urandom_range(0, 7));
    end
    simm = $urandom;
    for (int k = 0; k < NUM_FWD; k++) fwd_data[k] = $urandom;
    fwd_valid = NUM_FWD'($urandom);
  endtask

  typedef struct {
    logic [SEL_W-1:0] code;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'd0, 32'h0A, 32'h0B};
    tbl[1] = '{3'd1, 32'h05, 32'h05};
    tbl[2] = '{3'd2, 32'h11, 32'h11};
    tbl[3] = '{3'd3, 32'h22, 32'h22};
    tbl[4] = '{3'd4, 32'h33, 32'h33};
    tbl[5] = '{3'd5, 32'h0A, 32'h0B};
    tbl[6] = '{3'd6, 32'h0A, 32'h0B};
    tbl[7] = '{3'd7, 32'h0A, 32'h0B};

    // Reset with ex_freeze asserted must still clear state
    rst = 0; ex_freeze = 1; id_freeze = 1;
    randomize_inputs();
    step();
    chk("rst_operand0", operand[0], 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    randomize_inputs();
    step();

    // Select-code sweep, both operands on the same code
    rst = 1; ex_freeze = 0; id_freeze = 0;
    rf_data[0] = 32'hA; rf_data[1] = 32'hB; simm = 32'h5;
    fwd_data[0] = 32'h11; fwd_data[1] = 32'h22; fwd_data[2] = 32'h33;
    fwd_valid = '1;
    for (int t = 0; t < 8; t++) begin
      sel[0] = tbl[t].code; sel[1] = tbl[t].code;
      settle();
      chk($sformatf("tbl%0d_mux0", t), muxed[0], tbl[t].e0);
      chk($sformatf("tbl%0d_mux1", t), muxed[1], tbl[t].e1);
      tick();
      chk($sformatf("tbl%0d_op0", t), operand[0], tbl[t].e0);
      chk($sformatf("tbl%0d_op1", t), operand[1], tbl[t].e1);
    end

    // Forwarding not ready for 3 cycles, then resolves
    sel[0] = 0; sel[1] = 0; rf_data[0] = 32'hCAFE;
    step();
    sel[0] = 2; fwd_valid = 3'b110; fwd_data[0] = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("fwd_wait_stall", 32'(fwd_stall), 32'h1);
      tick();
      chk("fwd_wait_op0", operand[0], 32'hCAFE);
      chk("fwd_wait_opv", 32'(op_valid), 32'h0);
    end
    fwd_valid = 3'b111; fwd_data[0] = 32'h1234;
    settle();
    chk("fwd_ready_stall", 32'(fwd_stall), 32'h0);
    tick();
    chk("fwd_ready_op0", operand[0], 32'h1234);
    chk("fwd_ready_opv", 32'(op_valid), 32'h1);

    // Freeze save
    sel[0] = 0; rf_data[0] = 32'h77; id_freeze = 1;
    step();
    chk("frz_op0", operand[0], 32'h77);
    chk("frz_saved0", 32'(saved[0]), 32'h1);
    rf_data[0] = 32'h88;
    step();
    chk("frz_hold_op0", operand[0], 32'h77);
    id_freeze = 0;
    step();
    chk("frz_rel_saved0", 32'(saved[0]), 32'h0);
    chk("frz_rel_op0", operand[0], 32'h77);
    step();
    chk("frz_live_op0", operand[0], 32'h88);

    // ex_freeze holds everything while a stall is raised
    rf_data[0] = 32'h42;
    step();
    ex_freeze = 1; sel[0] = 2; fwd_valid = 3'b000;
    for (int c = 0; c < 2; c++) begin
      rf_data[0] = $urandom; rf_data[1] = $urandom; sel[1] = SEL_W'(c);
      settle();
      chk("exf_stall", 32'(fwd_stall), 32'h1);
      tick();
      chk("exf_op0", operand[0], 32'h42);
      chk("exf_saved0", 32'(saved[0]), 32'h0);
      chk("exf_opv", 32'(op_valid), 32'h1);
    end

    // Reset in the middle of a stall and freeze
    rst = 0; id_freeze = 1;
    step();
    chk("rst_mid_op0", operand[0], 32'h0);
    chk("rst_mid_opv", 32'(op_valid), 32'h0);

    // Mixed lanes: op0 deferred on fwd[1], op1 captures simm
    rst = 1; ex_freeze = 0; id_freeze = 0;
    sel[0] = 0; sel[1] = 0; rf_data[0] = 32'h55; fwd_valid = '1;
    step();
    sel[0] = 3; fwd_valid = 3'b101; sel[1] = 1; simm = 32'h9;
    step();
    chk("mix_op1", operand[1], 32'h9);
    chk("mix_op0", operand[0], 32'h55);
    chk("mix_opv", 32'(op_valid), 32'h0);

    // Randomized run against the model
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      rst       = ($urandom_range(0, 31) != 0);
      id_freeze = ($urandom_range(0, 3) == 0);
      ex_freeze = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
